// File: rtl/viterbi_ctrl_if.sv
// Handshake and datapath-control bundle between the Viterbi sequencer and its
// ACS array, survivor memory, symbol source and decoded-bit consumer.
interface viterbi_ctrl_if #(
  parameter int unsigned TB_DEPTH = 16
);
  localparam int unsigned AW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

  logic          sym_valid;
  logic          sym_ready;
  logic [3:0]    pm_msb;
  logic          acs_en;
  logic          norm_sel;
  logic          sm_wr_en;
  logic [AW-1:0] sm_waddr;
  logic [AW-1:0] sm_raddr;
  logic [3:0]    sm_rdata;
  logic          bit_valid;
  logic          bit_ready;
  logic          bit_out;
  logic          blk_done;

  // Controller side.
  modport master (
    input  sym_valid, pm_msb, sm_rdata, bit_ready,
    output sym_ready, acs_en, norm_sel, sm_wr_en, sm_waddr, sm_raddr,
           bit_valid, bit_out, blk_done
  );

  // Datapath / source / consumer side.
  modport slave (
    output sym_valid, pm_msb, sm_rdata, bit_ready,
    input  sym_ready, acs_en, norm_sel, sm_wr_en, sm_waddr, sm_raddr,
           bit_valid, bit_out, blk_done
  );
endinterface

// File: rtl/viterbi_ctrl.sv
// Sequencer for a 4-state (K=3, rate-1/2) Viterbi decoder: accepts a block of
// symbols into the ACS array, traces back through survivor memory from state 0,
// then streams the decoded bits out oldest-first.
module viterbi_ctrl #(
  parameter int unsigned TB_DEPTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  viterbi_ctrl_if.master bus
);
  localparam int unsigned AW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(TB_DEPTH - 1);

  typedef enum logic [1:0] {StAccept, StTrace, StOutput} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wcnt_q, wcnt_d;
  logic [AW-1:0]       rcnt_q, rcnt_d;
  logic [AW-1:0]       ocnt_q, ocnt_d;
  logic [1:0]          tb_state_q, tb_state_d;
  logic [TB_DEPTH-1:0] lifo_q, lifo_d;
  logic                sym_fire, bit_fire;

  // Next-state, counters, LIFO and all controller outputs.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    ocnt_d     = ocnt_q;
    tb_state_d = tb_state_q;
    lifo_d     = lifo_q;

    bus.sym_ready = (state_q == StAccept);
    bus.bit_valid = (state_q == StOutput);
    sym_fire      = bus.sym_valid & bus.sym_ready;
    bit_fire      = bus.bit_valid & bus.bit_ready;

    bus.acs_en    = sym_fire;
    bus.sm_wr_en  = sym_fire;
    // Normalize only when every metric has crossed 32, and only on an update.
    bus.norm_sel  = sym_fire & (&bus.pm_msb);
    bus.sm_waddr  = wcnt_q;
    bus.sm_raddr  = (state_q == StTrace) ? rcnt_q : '0;
    // LIFO bit 0 is the top: the bit of the oldest symbol of the block.
    bus.bit_out   = (state_q == StOutput) & lifo_q[0];
    bus.blk_done  = bit_fire & (ocnt_q == LastIdx);

    case (state_q)
      StAccept: begin
        if (sym_fire) begin
          if (wcnt_q == LastIdx) begin
            wcnt_d     = '0;
            rcnt_d     = LastIdx;
            tb_state_d = 2'b00;  // tail-terminated encoder ends in state 0
            state_d    = StTrace;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StTrace: begin
        // tb_state[1] is the input bit that led into this state.
        lifo_d     = {lifo_q[TB_DEPTH-2:0], tb_state_q[1]};
        tb_state_d = {tb_state_q[0], bus.sm_rdata[tb_state_q]};
        if (rcnt_q == '0) begin
          ocnt_d  = '0;
          state_d = StOutput;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      StOutput: begin
        if (bit_fire) begin
          lifo_d = {1'b0, lifo_q[TB_DEPTH-1:1]};
          if (ocnt_q == LastIdx) begin
            ocnt_d  = '0;
            state_d = StAccept;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      default: state_d = StAccept;
    endcase
  end

  // State register with asynchronous clear of all partial block state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAccept;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      tb_state_q <= 2'b00;
      lifo_q     <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      tb_state_q <= tb_state_d;
      lifo_q     <= lifo_d;
    end
  end
endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed/randomized bench for viterbi_ctrl. Survivor memory is built from a
// K=3 encoder model so the true path's decisions recover the message bits.
module tb_viterbi_ctrl;
  localparam int unsigned T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] mem [T];
  logic       msg [T];

  viterbi_ctrl_if #(.TB_DEPTH(T)) bus ();

  viterbi_ctrl #(.TB_DEPTH(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational survivor-memory read.
  always_comb bus.sm_rdata = mem[bus.sm_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  // mode 0: all-zero message/memory; 1: message 1,0,1,1,0,0,0..; 2: random.
  // Encoder state after bit t is {b[t], b[t-1]}; the decision stored for that
  // state is the bit shifted out, b[t-2]. Off-path decisions are noise.
  task automatic build(input int mode);
    logic [1:0] s;
    for (int t = 0; t < T; t++) begin
      case (mode)
        0: msg[t] = 1'b0;
        1: msg[t] = (t == 0 || t == 2 || t == 3);
        default: msg[t] = (t < T - 2) ? 1'($urandom) : 1'b0;
      endcase
    end
    for (int t = 0; t < T; t++) begin
      s = {msg[t], (t >= 1) ? msg[t-1] : 1'b0};
      mem[t] = (mode == 0) ? 4'h0 : 4'($urandom);
      mem[t][s] = (t >= 2) ? msg[t-2] : 1'b0;
    end
  endtask

  task automatic accept_phase(input bit gaps);
    int sent = 0;
    int guard = 0;
    bit v;
    while (sent < T && guard < 400) begin
      @(negedge clk);
      guard++;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.sym_valid = v;
      bus.pm_msb = 4'($urandom);
      bus.bit_ready = 1'($urandom);
      #1;
      chk("acc_sym_ready", 32'(bus.sym_ready), 32'd1);
      chk("acc_acs_en", 32'(bus.acs_en), 32'(v));
      chk("acc_sm_wr_en", 32'(bus.sm_wr_en), 32'(v));
      chk("acc_norm_sel", 32'(bus.norm_sel), 32'(v && bus.pm_msb == 4'hf));
      chk("acc_bit_valid", 32'(bus.bit_valid), 32'd0);
      if (v) begin
        chk("acc_sm_waddr", 32'(bus.sm_waddr), 32'(sent));
        sent++;
      end
    end
    if (sent < T) timeout("accept_phase");
  endtask

  task automatic trace_phase();
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      bus.sym_valid = 1'b1;  // must be ignored
      bus.pm_msb = 4'hf;
      #1;
      chk("tr_sym_ready", 32'(bus.sym_ready), 32'd0);
      chk("tr_acs_en", 32'(bus.acs_en), 32'd0);
      chk("tr_norm_sel", 32'(bus.norm_sel), 32'd0);
      chk("tr_sm_wr_en", 32'(bus.sm_wr_en), 32'd0);
      chk("tr_sm_raddr", 32'(bus.sm_raddr), 32'(T - 1 - i));
      chk("tr_bit_valid", 32'(bus.bit_valid), 32'd0);
    end
  endtask

  // rmode 0: ready always; 1: pattern 1,0,0,1; 2: random.
  // stop_after > 0 returns inside OUTPUT after that many cycles.
  task automatic output_phase(input int rmode, input int stop_after);
    int popped = 0;
    int k = 0;
    bit r;
    logic [3:0] pat = 4'b1001;
    while (popped < T && k < 400) begin
      @(negedge clk);
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[k % 4] : 1'($urandom);
      bus.bit_ready = r;
      bus.sym_valid = 1'($urandom);
      #1;
      chk("out_bit_valid", 32'(bus.bit_valid), 32'd1);
      chk("out_sym_ready", 32'(bus.sym_ready), 32'd0);
      chk("out_acs_en", 32'(bus.acs_en), 32'd0);
      chk("out_bit", 32'(bus.bit_out), 32'(msg[popped]));
      chk("out_blk_done", 32'(bus.blk_done), 32'(r && popped == T - 1));
      if (r) popped++;
      k++;
      if (stop_after > 0 && k == stop_after) return;
    end
    if (popped < T) begin
      timeout("output_phase");
      return;
    end
    @(negedge clk);
    bus.sym_valid = 1'b0;
    bus.bit_ready = 1'b1;
    #1;
    chk("post_sym_ready", 32'(bus.sym_ready), 32'd1);
    chk("post_bit_valid", 32'(bus.bit_valid), 32'd0);
    chk("post_sm_waddr", 32'(bus.sm_waddr), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sym_ready"}, 32'(bus.sym_ready), 32'd1);
    chk({tag, "_acs_en"}, 32'(bus.acs_en), 32'd0);
    chk({tag, "_norm_sel"}, 32'(bus.norm_sel), 32'd0);
    chk({tag, "_sm_wr_en"}, 32'(bus.sm_wr_en), 32'd0);
    chk({tag, "_sm_waddr"}, 32'(bus.sm_waddr), 32'd0);
    chk({tag, "_sm_raddr"}, 32'(bus.sm_raddr), 32'd0);
    chk({tag, "_bit_valid"}, 32'(bus.bit_valid), 32'd0);
    chk({tag, "_bit_out"}, 32'(bus.bit_out), 32'd0);
    chk({tag, "_blk_done"}, 32'(bus.blk_done), 32'd0);
  endtask

  initial begin
    bus.sym_valid = 1'b0;
    bus.pm_msb = 4'h0;
    bus.bit_ready = 1'b0;
    build(0);
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // norm_sel directed cases (consumes two symbols, then reset clears them).
    @(negedge clk);
    bus.sym_valid = 1'b1; bus.pm_msb = 4'b1111; #1;
    chk("norm_1111", 32'(bus.norm_sel), 32'd1);
    @(negedge clk);
    bus.pm_msb = 4'b1110; #1;
    chk("norm_1110", 32'(bus.norm_sel), 32'd0);
    @(negedge clk);
    bus.sym_valid = 1'b0; bus.pm_msb = 4'b1111; #1;
    chk("norm_novalid", 32'(bus.norm_sel), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst2");
    @(negedge clk);
    rst_n = 1'b1;

    // Block A: all zeros, full rate.
    build(0);
    accept_phase(1'b0);
    trace_phase();
    output_phase(0, 0);

    // Block B: message 1,0,1,1,0,0 with stalled consumer.
    build(1);
    accept_phase(1'b1);
    trace_phase();
    output_phase(1, 0);

    // Random blocks.
    for (int b = 0; b < 3; b++) begin
      build(2);
      accept_phase(1'b1);
      trace_phase();
      output_phase(2, 0);
    end

    // Reset mid-OUTPUT with bit_valid high.
    build(2);
    accept_phase(1'b0);
    trace_phase();
    output_phase(1, 3);
    chk("mid_bit_valid", 32'(bus.bit_valid), 32'd1);
    bus.sym_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst3");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.sym_valid = 1'b1;
      #1;
      chk("rst3_acs_en", 32'(bus.acs_en), 32'd1);
      chk("rst3_sm_waddr", 32'(bus.sm_waddr), 32'(i));
    end
    @(negedge clk);
    bus.sym_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
